// File: rtl/evenzeroes_pkg.sv
// Shared types and constants for the even-zeroes dual-rail sender.
// Rail codes are {rail1, rail0}.
package evenzeroes_pkg;

  localparam int EZ_WIDTH_DEF   = 8;
  localparam int EZ_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRIVE    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_WAIT_RTZ = 3'd4,
    ST_DONE     = 3'd5
  } ez_state_t;

  localparam logic [1:0] EZ_NULL    = 2'b00;
  localparam logic [1:0] EZ_ZERO    = 2'b01;
  localparam logic [1:0] EZ_ONE     = 2'b10;
  localparam logic [1:0] EZ_ILLEGAL = 2'b11;

  function automatic logic [1:0] ez_encode(input logic b);
    return b ? EZ_ONE : EZ_ZERO;
  endfunction

  // Zero-count parity after including bit b, starting from odd flag zodd.
  function automatic logic ez_zodd_next(input logic zodd, input logic b);
    return zodd ^ ~b;
  endfunction

endpackage

// File: rtl/ez_rail_sync.sv
// Two-flop synchronizer for the 2-bit parity acknowledge rails.
// Used by evenzeroes_sender only when EVENZEROES_SENDER_SYNC_EN is defined.
module ez_rail_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [1:0] meta_d, meta_q;
  logic [1:0] sync_d, sync_q;

  // Next values of the two synchronizer stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/evenzeroes_sender.sv
// Four-phase dual-rail initiator for the even-zeroes parity channel.
// Define EVENZEROES_SENDER_SYNC_EN to put parity0/parity1 through two-flop synchronizers.
module evenzeroes_sender
  import evenzeroes_pkg::*;
#(
  parameter int WIDTH   = EZ_WIDTH_DEF,
  parameter int TIMEOUT = EZ_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             bit0,
  output logic             bit1,
  input  logic             parity0,
  input  logic             parity1,
  output logic             out_valid,
  output logic             out_parity,
  output logic             out_mismatch,
  output logic             out_error
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0] ack_raw;
  logic [1:0] ack_s;

  assign ack_raw = {parity1, parity0};

`ifdef EVENZEROES_SENDER_SYNC_EN
  ez_rail_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_raw),
    .q   (ack_s)
  );
`else
  assign ack_s = ack_raw;
`endif

  ez_state_t        state_d, state_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [IW-1:0]    idx_d, idx_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic [1:0]       rail_d, rail_q;
  logic             zodd_d, zodd_q;
  logic             par_d, par_q;
  logic             mis_d, mis_q;
  logic             err_d, err_q;
  logic             in_ready_d, in_ready_q;
  logic             out_valid_d, out_valid_q;
  logic             out_parity_d, out_parity_q;
  logic             out_mismatch_d, out_mismatch_q;
  logic             out_error_d, out_error_q;

  logic cur_bit_s;
  logic last_bit_s;
  logic ack_illegal_s;
  logic ack_onehot_s;
  logic ack_null_s;
  logic timeout_hit_s;
  logic zodd_bit_s;

  // Decode of the current bit and the acknowledge rails
  always_comb begin
    cur_bit_s     = data_q[idx_q];
    last_bit_s    = (idx_q == IW'(WIDTH - 1));
    ack_illegal_s = (ack_s == EZ_ILLEGAL);
    ack_onehot_s  = (ack_s == EZ_ZERO) || (ack_s == EZ_ONE);
    ack_null_s    = (ack_s == EZ_NULL);
    timeout_hit_s = (cnt_q == CW'(TIMEOUT - 1));
    zodd_bit_s    = ez_zodd_next(zodd_q, cur_bit_s);
  end

  // Handshake FSM: next state, datapath and registered outputs
  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    rail_d         = rail_q;
    zodd_d         = zodd_q;
    par_d          = par_q;
    mis_d          = mis_q;
    err_d          = err_q;

    case (state_q)
      ST_IDLE: begin
        // Acks arriving while idle are ignored.
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          idx_d   = '0;
          mis_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (ack_illegal_s) begin
          err_d   = 1'b1;
          rail_d  = EZ_NULL;
          state_d = ST_DONE;
        end else begin
          rail_d  = ez_encode(cur_bit_s);
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_illegal_s) begin
          err_d   = 1'b1;
          rail_d  = EZ_NULL;
          state_d = ST_DONE;
        end else if (ack_onehot_s) begin
          // parity1 is expected exactly when the updated zero count is even.
          mis_d   = mis_q | (ack_s[1] == zodd_bit_s);
          par_d   = ack_s[1];
          zodd_d  = zodd_bit_s;
          state_d = ST_RELEASE;
        end else if (timeout_hit_s) begin
          err_d   = 1'b1;
          rail_d  = EZ_NULL;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (ack_illegal_s) begin
          err_d   = 1'b1;
          rail_d  = EZ_NULL;
          state_d = ST_DONE;
        end else begin
          rail_d  = EZ_NULL;
          cnt_d   = '0;
          state_d = ST_WAIT_RTZ;
        end
      end
      ST_WAIT_RTZ: begin
        if (ack_illegal_s) begin
          err_d   = 1'b1;
          rail_d  = EZ_NULL;
          state_d = ST_DONE;
        end else if (ack_null_s) begin
          if (last_bit_s) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_DRIVE;
          end
        end else if (timeout_hit_s) begin
          err_d   = 1'b1;
          rail_d  = EZ_NULL;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        rail_d  = EZ_NULL;
        state_d = ST_IDLE;
      end
      default: begin
        rail_d  = EZ_NULL;
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      out_parity_d   = par_d;
      out_mismatch_d = mis_d;
      out_error_d    = err_d;
    end else begin
      out_parity_d   = out_parity_q;
      out_mismatch_d = out_mismatch_q;
      out_error_d    = out_error_q;
    end
  end

  // State and output registers; reset drops the rails immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      data_q         <= '0;
      idx_q          <= '0;
      cnt_q          <= '0;
      rail_q         <= EZ_NULL;
      zodd_q         <= 1'b0;
      par_q          <= 1'b0;
      mis_q          <= 1'b0;
      err_q          <= 1'b0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_parity_q   <= 1'b0;
      out_mismatch_q <= 1'b0;
      out_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_q         <= data_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      rail_q         <= rail_d;
      zodd_q         <= zodd_d;
      par_q          <= par_d;
      mis_q          <= mis_d;
      err_q          <= err_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_parity_q   <= out_parity_d;
      out_mismatch_q <= out_mismatch_d;
      out_error_q    <= out_error_d;
    end
  end

  assign bit0         = rail_q[0];
  assign bit1         = rail_q[1];
  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_parity   = out_parity_q;
  assign out_mismatch = out_mismatch_q;
  assign out_error    = out_error_q;

endmodule

// File: tb/tb_evenzeroes_sender.sv
// Directed bench for evenzeroes_sender with a behavioural even-zeroes responder.
module tb_evenzeroes_sender;

  localparam int W  = 4;
  localparam int TO = 10;

  localparam int M_NORM    = 0;
  localparam int M_FLIP    = 1;
  localparam int M_SILENT  = 2;
  localparam int M_ILLEGAL = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         bit0, bit1;
  logic         parity0, parity1;
  logic         out_valid, out_parity, out_mismatch, out_error;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = M_NORM;

  logic rz_odd, rail_prev, b0_prev;
  int   hs_cnt;
  logic ack_prev = 1'b0;
  logic ack_q[$];
  int   ov_total   = 0;
  int   both_total = 0;

  evenzeroes_sender #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .bit0         (bit0),
    .bit1         (bit1),
    .parity0      (parity0),
    .parity1      (parity1),
    .out_valid    (out_valid),
    .out_parity   (out_parity),
    .out_mismatch (out_mismatch),
    .out_error    (out_error)
  );

  always #5 clk = ~clk;

  // Zero-latency responder: answers the rail combinationally
  always_comb begin
    parity0 = 1'b0;
    parity1 = 1'b0;
    if (bit0 || bit1) begin
      if (mode == M_ILLEGAL) begin
        parity0 = 1'b1;
        parity1 = 1'b1;
      end else if (mode != M_SILENT) begin
        parity1 = ~(rz_odd ^ bit0) ^ ((mode == M_FLIP) && (hs_cnt == 0));
        parity0 = ~parity1;
      end
    end
  end

  // Responder state commits when the rail returns to zero
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rz_odd    <= 1'b0;
      rail_prev <= 1'b0;
      b0_prev   <= 1'b0;
      hs_cnt    <= 0;
    end else begin
      rail_prev <= bit0 | bit1;
      b0_prev   <= bit0;
      if (rail_prev && !(bit0 | bit1) && (mode == M_NORM || mode == M_FLIP)) begin
        rz_odd <= rz_odd ^ b0_prev;
        hs_cnt <= hs_cnt + 1;
      end
    end
  end

  // Channel monitor: ack log, out_valid pulses, dual-rail violations
  always @(posedge clk) begin
    if ((parity0 || parity1) && !ack_prev) ack_q.push_back(parity1);
    ack_prev <= parity0 || parity1;
    if (out_valid) ov_total <= ov_total + 1;
    if (bit0 && bit1) both_total <= both_total + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_rails", {bit1, bit0}, 2'b00);
    check("rst_outs", {out_valid, out_parity, out_mismatch, out_error}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_after", in_ready, 1'b1);
  endtask

  task automatic start_word(input logic [W-1:0] d);
    for (int k = 0; k < 100; k++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    check("start_ready", in_ready, 1'b1);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_word(input string tag, input logic [W-1:0] d, input logic [3:0] exp_acks,
                          input logic exp_par, input logic exp_mis, input logic exp_err);
    int         base;
    int         ov0;
    int         both0;
    logic [3:0] acks;
    base  = ack_q.size();
    ov0   = ov_total;
    both0 = both_total;
    start_word(d);
    for (int k = 0; k < 200; k++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    check({tag, "_done"}, out_valid, 1'b1);
    check({tag, "_parity"}, out_parity, exp_par);
    check({tag, "_mismatch"}, out_mismatch, exp_mis);
    check({tag, "_error"}, out_error, exp_err);
    for (int i = 0; i < 4; i++) acks[i] = (base + i < ack_q.size()) ? ack_q[base + i] : 1'bx;
    check({tag, "_ack_count"}, ack_q.size() - base, 4);
    check({tag, "_acks"}, acks, exp_acks);
    @(negedge clk);
    check({tag, "_one_pulse"}, ov_total - ov0, 1);
    check({tag, "_ready_again"}, in_ready, 1'b1);
    check({tag, "_hold"}, {out_valid, out_parity, out_mismatch, out_error},
          {1'b0, exp_par, exp_mis, exp_err});
    check({tag, "_one_rail"}, both_total - both0, 0);
  endtask

  initial begin
    int   hi;
    int   rises;
    int   ov0;
    logic seen_hi;

    do_reset();

    // Bits 0,1,0,1: acks parity0, parity0, parity1, parity1
    run_word("w1010", 4'b1010, 4'b1100, 1'b1, 1'b0, 1'b0);
    // zodd persists across words
    run_word("w1110", 4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    run_word("w1111", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Responder answers parity1 on bit 0 after reset
    do_reset();
    mode = M_FLIP;
    run_word("mism", 4'b1110, 4'b0001, 1'b0, 1'b1, 1'b0);

    // Silent responder: rail held for exactly TIMEOUT wait cycles
    mode = M_SILENT;
    start_word(4'b0001);
    hi = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bit0 || bit1) begin
        check("to_rail_is_one", {bit1, bit0}, 2'b10);
        hi++;
      end else if (hi > 0) begin
        break;
      end
    end
    check("to_wait_cycles", hi, TO);
    check("to_rails_low", {bit1, bit0}, 2'b00);
    check("to_result", {out_valid, out_mismatch, out_error}, 3'b101);
    @(negedge clk);
    check("to_ready_again", {in_ready, out_valid}, 2'b10);

    // Both ack rails high during WAIT_ACK
    mode = M_ILLEGAL;
    start_word(4'b0000);
    @(negedge clk);
    check("ill_rail_up", {bit1, bit0, parity1, parity0}, 4'b0111);
    @(negedge clk);
    check("ill_rails_drop", {bit1, bit0}, 2'b00);
    check("ill_result", {out_valid, out_error}, 2'b11);
    @(negedge clk);
    check("ill_ready_again", in_ready, 1'b1);

    // Reset while a rail is high drops it without waiting for a clock
    mode = M_NORM;
    do_reset();
    start_word(4'b0000);
    @(negedge clk);
    check("arst_rail_up", {bit1, bit0}, 2'b01);
    #2 rst = 1'b1;
    #1 check("arst_rails_async", {bit1, bit0, in_ready}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset during WAIT_RTZ of bit 2
    start_word(4'b1010);
    rises   = 0;
    seen_hi = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bit0 || bit1) begin
        seen_hi = 1'b1;
      end else if (seen_hi) begin
        seen_hi = 1'b0;
        rises++;
        if (rises == 3) break;
      end
    end
    check("mid_bits_sent", rises, 3);
    ov0 = ov_total;
    #1 rst = 1'b1;
    #1 check("mid_rst_outs", {bit1, bit0, in_ready, out_valid}, 4'b0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_no_valid", ov_total - ov0, 0);
    check("mid_ready", in_ready, 1'b1);
    run_word("w0000", 4'b0000, 4'b1010, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
